// File: rtl/adder_result_serializer.sv
// adder_result_serializer
// Buffers 4-bit {cout,sum} adder results in a small FIFO, keeps a saturating
// running total of every accepted value, and sends each buffered value out as
// a 7-bit frame on tx: start(0), 4 data bits LSB first, even parity, stop(1).
module adder_result_serializer #(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 4,
  parameter int ACC_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [2:0]                 in_sum,
  input  logic                       in_cout,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [ACC_W-1:0]           acc,
  output logic                       acc_sat,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [3:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [1:0]       bit_q, bit_d;
  logic [3:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_sat_q, acc_sat_d;
  logic             overflow_q, overflow_d;

  logic [3:0]       in_value;
  logic             push;
  logic             pop;
  logic             baud_end;
  logic [ACC_W:0]   acc_sum;

  assign in_value = {in_cout, in_sum};
  // Full is judged on the registered level only, so a same-cycle pop never frees a slot early.
  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == IDLE) && (level_q != '0);
  assign baud_end = (baud_q == BW'(BAUD_DIV - 1));
  assign acc_sum  = {1'b0, acc_q} + (ACC_W + 1)'(in_value);

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;
  assign acc        = acc_q;
  assign acc_sat    = acc_sat_q;
  assign overflow   = overflow_q;

  // FIFO storage write; pointers are cleared by reset so stale contents are never read.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr_q] <= in_value;
  end

  // FIFO pointers/level, saturating accumulator and sticky flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (push) begin
      if (acc_sum >= {1'b0, {ACC_W{1'b1}}}) begin
        acc_d     = {ACC_W{1'b1}};
        acc_sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  // Frame FSM: each non-idle state holds its bit for BAUD_DIV cycles.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          shreg_d = mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 2'd0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 2'd3) begin
            state_d = PARITY;
            tx_d    = ^shreg_q;
          end else begin
            bit_d = bit_q + 2'd1;
            tx_d  = shreg_q[bit_q + 2'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers; reset aborts any frame in progress and drives the line idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      acc_q      <= '0;
      acc_sat_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_adder_result_serializer.sv
// Directed bench for adder_result_serializer (DEPTH=4, BAUD_DIV=4, ACC_W=8).
module tb_adder_result_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_sum = 3'd0;
  logic       in_cout = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_level;
  logic [7:0] acc;
  logic       acc_sat;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  adder_result_serializer #(.DEPTH(4), .BAUD_DIV(4), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout),
    .in_ready(in_ready), .tx(tx), .tx_busy(tx_busy), .fifo_level(fifo_level),
    .acc(acc), .acc_sat(acc_sat), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait for a free slot, then present one value for a single edge.
  task automatic push_one(input logic [3:0] v);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    {in_cout, in_sum} = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a start bit, then verify every cycle of the 7 bits (4 cycles each).
  task automatic check_frame(input logic [3:0] v, input bit chk_idle);
    logic [6:0] pat;
    int n = 0;
    int bad;
    pat = {1'b1, ^v, v, 1'b0};
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check($sformatf("frame_v%0d_start", v), tx, 0);
    end else begin
      for (int b = 0; b < 7; b++) begin
        bad = 0;
        for (int c = 0; c < 4; c++) begin
          if (tx !== pat[b]) bad++;
          @(negedge clk);
        end
        check($sformatf("frame_v%0d_bit%0d_bad", v, b), bad, 0);
      end
      if (chk_idle) begin
        check($sformatf("frame_v%0d_busy_end", v), tx_busy, 0);
        check($sformatf("frame_v%0d_tx_end", v), tx, 1);
      end
    end
  endtask

  initial begin
    int n;
    int bad;

    // 1: reset held two cycles while in_valid is asserted
    in_valid = 1'b1;
    {in_cout, in_sum} = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_acc", acc, 0);
    check("rst_sat", acc_sat, 0);
    check("rst_overflow", overflow, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // 2: single value 11 -> 0,1,1,0,1,1,1
    push_one(4'd11);
    check("t2_level", fifo_level, 1);
    check("t2_acc", acc, 11);
    check_frame(4'd11, 1'b1);
    check("t2_level_end", fifo_level, 0);

    // 3: six back-to-back values 1..6 from empty; sixth is dropped
    do_reset();
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          check($sformatf("t3_ready_%0d", k), in_ready, (k < 6) ? 1 : 0);
          in_valid = 1'b1;
          {in_cout, in_sum} = 4'(k);
          @(negedge clk);
        end
        in_valid = 1'b0;
        check("t3_level_peak", fifo_level, 4);
        check("t3_overflow", overflow, 1);
        check("t3_acc", acc, 15);
      end
      begin
        for (int k = 1; k <= 5; k++) check_frame(4'(k), k == 5);
      end
    join
    check("t3_level_end", fifo_level, 0);

    // 4: saturation with seventeen 15s
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      push_one(4'd15);
      if (i == 16) begin
        check("t4_acc_16", acc, 240);
        check("t4_sat_16", acc_sat, 0);
      end
    end
    check("t4_acc_17", acc, 255);
    check("t4_sat_17", acc_sat, 1);
    push_one(4'd15);
    check("t4_acc_18", acc, 255);
    check("t4_sat_18", acc_sat, 1);
    check("t4_overflow", overflow, 0);

    // 5: reset during data bit 1 of a frame carrying 5
    do_reset();
    push_one(4'd5);
    repeat (12) @(negedge clk);
    check("t5_mid_busy", tx_busy, 1);
    check("t5_mid_tx", tx, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_tx", tx, 1);
    check("t5_rst_busy", tx_busy, 0);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_acc", acc, 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("t5_no_residual", bad, 0);

    // 6: push coinciding with an idle pop at level 2
    do_reset();
    fork
      begin
        push_one(4'd9);
        push_one(4'd6);
        push_one(4'd3);
        check("t6_level_2", fifo_level, 2);
        n = 0;
        while (tx_busy && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("t6_idle_seen", tx_busy, 0);
        in_valid = 1'b1;
        {in_cout, in_sum} = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_level_hold", fifo_level, 2);
      end
      begin
        check_frame(4'd9, 1'b0);
        check_frame(4'd6, 1'b0);
        check_frame(4'd3, 1'b0);
        check_frame(4'd12, 1'b1);
      end
    join
    check("t6_acc", acc, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
